trailing_shift_decoder: RTL and testbench
=========================================

Name: trailing_shift_decoder

Overview:
- Sequential inverse of the Shifter block. Shifter builds result = base << power; this block takes such a value and recovers base (the odd part) and power (the trailing-zero count).
- Used in the neural-network datapath to renormalise scaled products back into base/power form.
- Same start/done handshake as Shifter; iterative, one bit per cycle.

Parameters:
- WIDTH, 16, data width of value and base; power output is also WIDTH bits (zero-extended), matching Shifter's power input.
- MAX_SHIFT, WIDTH-1, upper bound on shift iterations.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- value  input  WIDTH  encoded operand; sampled only when start is accepted.
- start  input  1  request; accepted only in IDLE.
- base  output  WIDTH  decoded odd part (0 for zero input).
- power  output  WIDTH  trailing-zero count, zero-extended.
- zero  output  1  set when the accepted value was 0.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - Asynchronous while rst=1; takes effect even mid-operation, and the operation is aborted.
  - base=0, power=0, zero=0, done=0, busy=0, state=IDLE, work/count registers=0.
- State IDLE:
  - When start=1 at edge E0: work<=value, count<=0, go to SHIFT.
  - Outputs hold their last result.
- State SHIFT, evaluated each edge:
  - work==0: base<=0, power<=0, zero<=1, done<=1, go to DONE.
  - else if work[0]==1 or count==MAX_SHIFT: base<=work, power<=count, zero<=0, done<=1, go to DONE.
  - else: work<=work>>1 (logical shift), count<=count+1.
- State DONE:
  - done is high for exactly this one cycle.
  - Next edge: done<=0, go to IDLE.
  - start is ignored in DONE.
- Latency:
  - For nonzero input with k trailing zeros, done rises at edge E0+k+1.
  - For zero input, done rises at E0+1.
  - Worst case is 0x8000: E0+16.
- Handshake rules:
  - start while busy=1 is ignored; no queuing.
  - start held high continuously re-triggers on the first IDLE cycle after DONE.
  - After reset deassertion, start is sampled at the first edge.
- Arithmetic and widths:
  - count is clog2(WIDTH) bits internally and never exceeds MAX_SHIFT.
  - power upper bits are always 0.
- Outputs:
  - base, power and zero are registered, and change only on the completion edge or on reset.
  - value may change freely after acceptance.

Optional Feature:
- Macro: TRAILING_SHIFT_FAST_SKIP_EN.
- Defined:
  - In SHIFT, if work!=0 and work[3:0]==0, then work<=work>>4 and count<=count+4 in one cycle.
  - This cannot overflow, because count+tz <= MAX_SHIFT.
  - Otherwise single-bit behaviour applies.
  - 0x8000 completes at E0+7.
- Not defined:
  - Strictly one bit per cycle, with latency as given above.
  - Results are identical in both builds; only latency differs.

Test Plan:
- value=0x0028, start pulse at E0 -> done at E0+4 (E0+4 with FAST_SKIP too), base=0x0005, power=3, zero=0.
- value=0x8000 -> base=0x0001, power=15; done at E0+16, or E0+7 with TRAILING_SHIFT_FAST_SKIP_EN.
- value=0x0000 -> done at E0+1, base=0, power=0, zero=1; then value=0x0001 -> done at E0+1, base=1, power=0, zero=0.
- Round trip: Shifter base=0x0007, power=5 gives 0x00E0; feed to this block -> base=0x0007, power=5.
- value=0x0100 accepted; second start with value=0x0003 during SHIFT and during DONE -> ignored; result base=1, power=8, and exactly one done pulse.
- value=0x4000 accepted; assert rst for 1 cycle at E0+5 -> all outputs immediately 0, busy=0, no done pulse; a new start with 0x0006 gives base=3, power=1.

Source files
------------

// File: rtl/trailing_shift_decoder.sv
`timescale 1ns/1ps
// trailing_shift_decoder
//   Iterative inverse of the Shifter block: takes value = base << power and
//   recovers the odd part (base) and the trailing-zero count (power), one bit
//   per cycle, using the same start/done handshake as Shifter.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset, aborts any operation
//   value  in   WIDTH  operand, sampled only when start is accepted in IDLE
//   start  in   request, ignored while busy
//   base   out  WIDTH  odd part of the accepted value (0 for zero input)
//   power  out  WIDTH  trailing-zero count, zero-extended
//   zero   out  accepted value was 0
//   busy   out  high in SHIFT and DONE
//   done   out  one-cycle completion pulse
//
// Build option
//   TRAILING_SHIFT_FAST_SKIP_EN : when the low nibble of the working value is
//   all zero, shift by four in one cycle. Results are unchanged; only latency
//   drops.
//
// state  | meaning
// IDLE   | waiting for start, outputs hold the last result
// SHIFT  | stripping trailing zeros from work_q, counting in count_q
// DONE   | result registered, done high for this one cycle

module trailing_shift_decoder #(
   parameter int WIDTH     = 16,
   parameter int MAX_SHIFT = WIDTH - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] value,
   input  logic             start,
   output logic [WIDTH-1:0] base,
   output logic [WIDTH-1:0] power,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_SHIFT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] work_q,  work_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] base_q,  base_d;
   logic [WIDTH-1:0] power_q, power_d;
   logic             zero_q,  zero_d;
   logic             done_q,  done_d;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         count_q <= '0;
         base_q  <= '0;
         power_q <= '0;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         count_q <= count_d;
         base_q  <= base_d;
         power_q <= power_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      count_d = count_q;
      base_d  = base_q;
      power_d = power_q;
      zero_d  = zero_q;
      done_d  = done_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               work_d  = value;
               count_d = '0;
               state_d = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (work_q == '0) begin
               base_d  = '0;
               power_d = '0;
               zero_d  = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (work_q[0] || (count_q == MAX_C)) begin
               base_d  = work_q;
               power_d = WIDTH'(count_q);
               zero_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
`ifdef TRAILING_SHIFT_FAST_SKIP_EN
            end else if (work_q[3:0] == 4'b0000) begin
               // Nonzero work with four trailing zeros has at least four more
               // shifts to go, so count + 4 stays within MAX_SHIFT.
               work_d  = work_q >> 4;
               count_d = count_q + CW'(4);
`endif
            end else begin
               work_d  = work_q >> 1;
               count_d = count_q + CW'(1);
            end
         end

         S_DONE: begin
            done_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            done_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      base  = base_q;
      power = power_q;
      zero  = zero_q;
      done  = done_q;
      busy  = (state_q != S_IDLE);
   end

endmodule

// File: tb/tb_trailing_shift_decoder.sv
`timescale 1ns/1ps
module tb_trailing_shift_decoder;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] value;
   logic [W-1:0] base;
   logic [W-1:0] power;
   logic         zero;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] prev_base  = '0;
   logic [W-1:0] prev_power = '0;
   logic         prev_zero  = 1'b0;

   always #5 clk = ~clk;

   trailing_shift_decoder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .value (value),
      .start (start),
      .base  (base),
      .power (power),
      .zero  (zero),
      .busy  (busy),
      .done  (done)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Reference: odd part and trailing-zero count by plain arithmetic;
   // latency from the number of shift steps needed.
   task automatic model(input logic [W-1:0] v, output logic [W-1:0] b,
                        output logic [W-1:0] p, output logic z, output int lat);
      int tz;
      tz = 0;
      if (v == '0) begin
         b = '0; p = '0; z = 1'b1; lat = 1;
      end else begin
         while (v[tz] == 1'b0) tz++;
         b = v >> tz;
         p = W'(tz);
         z = 1'b0;
`ifdef TRAILING_SHIFT_FAST_SKIP_EN
         lat = tz / 4 + tz % 4 + 1;
`else
         lat = tz + 1;
`endif
      end
   endtask

   task automatic run_op(input logic [W-1:0] v, input bit disturb);
      logic [W-1:0] eb, ep;
      logic         ez;
      int           lat, n;
      bit           seen;
      model(v, eb, ep, ez, lat);
      @(negedge clk);
      value = v;
      start = 1'b1;
      @(posedge clk); #1;
      if (disturb) begin
         start = 1'b1;
         value = 16'h0003;
      end else begin
         start = 1'b0;
         value = W'($urandom);
      end
      check("busy_after_start", 64'(busy), 64'(1));
      check("outputs_hold", 64'({base, power, zero}), 64'({prev_base, prev_power, prev_zero}));
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done) seen = 1'b1;
         else if (!disturb) value = W'($urandom);
      end
      check("done_seen", 64'(seen), 64'(1));
      check("latency", 64'(n), 64'(lat));
      check("base", 64'(base), 64'(eb));
      check("power", 64'(power), 64'(ep));
      check("zero", 64'(zero), 64'(ez));
      check("busy_in_done", 64'(busy), 64'(1));
      prev_base = eb; prev_power = ep; prev_zero = ez;
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'(0));
      check("busy_back_idle", 64'(busy), 64'(0));
      start = 1'b0;
   endtask

   initial begin
      int pulses;
      logic [W-1:0] v;
      rst = 1'b1; start = 1'b0; value = '0;
      repeat (2) @(negedge clk);
      check("rst_base", 64'(base), 64'(0));
      check("rst_power", 64'(power), 64'(0));
      check("rst_flags", 64'({zero, busy, done}), 64'(0));
      rst = 1'b0;

      run_op(16'h0028, 1'b0);
      run_op(16'h8000, 1'b0);
      run_op(16'h0000, 1'b0);
      run_op(16'h0001, 1'b0);
      run_op(16'h00E0, 1'b0);
      run_op(16'h0100, 1'b1);

      // Abort mid-operation with an asynchronous reset
      @(negedge clk);
      value = 16'h4000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_base", 64'(base), 64'(0));
      check("abort_power", 64'(power), 64'(0));
      check("abort_flags", 64'({zero, busy, done}), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("abort_no_done", 64'(pulses), 64'(0));
      prev_base = '0; prev_power = '0; prev_zero = 1'b0;
      run_op(16'h0006, 1'b0);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) v = '0;
         else v = W'($urandom << $urandom_range(0, 15));
         run_op(v, bit'($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
